// File: rtl/uart_axi4lite_master.sv
// UART-to-AXI4-Lite debug bridge: parses 'W'/'R' command frames from the RX byte stream,
// performs one AXI4-Lite access and returns a status byte (plus read data) on the TX stream.
module uart_axi4lite_master #(
    parameter int AXI_AWIDTH   = 32,
    parameter int AXI_DWIDTH   = 32,
    parameter int BYTE_TIMEOUT = 0
) (
    input  logic                    AXI_ACLK,
    input  logic                    AXI_ARESETN,
    input  logic [7:0]              RX_DO,
    input  logic                    RX_DRDY,
    output logic [7:0]              TX_DI,
    output logic                    TX_DRDY,
    input  logic                    TX_DONE,
    output logic                    BUSY,
    output logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
    output logic                    AXI_AWVALID,
    input  logic                    AXI_AWREADY,
    output logic [AXI_DWIDTH-1:0]   AXI_WDATA,
    output logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
    output logic                    AXI_WVALID,
    input  logic                    AXI_WREADY,
    input  logic [1:0]              AXI_BRESP,
    input  logic                    AXI_BVALID,
    output logic                    AXI_BREADY,
    output logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
    output logic                    AXI_ARVALID,
    input  logic                    AXI_ARREADY,
    input  logic [AXI_DWIDTH-1:0]   AXI_RDATA,
    input  logic [1:0]              AXI_RRESP,
    input  logic                    AXI_RVALID,
    output logic                    AXI_RREADY
);

    localparam int TW = (BYTE_TIMEOUT > 0) ? $clog2(BYTE_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_DATA, S_WR_AD, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_TX_SEND, S_TX_WAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic [AXI_AWIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DWIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DWIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              resp_q, resp_d;
    logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
    logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
    logic [TW-1:0]           tmo_q, tmo_d;

    logic frame_st, tmo_hit, in_idle, cmd_ok, frame_byte, frame_last;
    logic wr_done, b_hs, ar_hs, r_hs, tx_last;

    always_comb begin
        frame_st   = (state_q == S_ADDR) || (state_q == S_DATA);
        tmo_hit    = (BYTE_TIMEOUT != 0) && frame_st && (tmo_q == TW'(BYTE_TIMEOUT));
        // A timed-out frame behaves like IDLE this cycle so a coincident byte is a new command
        in_idle    = (state_q == S_IDLE) || tmo_hit;
        cmd_ok     = RX_DRDY && ((RX_DO == 8'h57) || (RX_DO == 8'h52));
        frame_byte = RX_DRDY && frame_st && !tmo_hit;
        frame_last = frame_byte && (cnt_q == 3'd3);
        wr_done    = (state_q == S_WR_AD) && !(awvalid_q && !AXI_AWREADY)
                                          && !(wvalid_q && !AXI_WREADY);
        b_hs       = bready_q && AXI_BVALID;
        ar_hs      = arvalid_q && AXI_ARREADY;
        r_hs       = rready_q && AXI_RVALID;
        tx_last    = is_wr_q ? (cnt_q == 3'd0) : (cnt_q == 3'd4);
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_idle) begin
            state_d = cmd_ok ? S_ADDR : S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:    if (frame_last) state_d = is_wr_q ? S_DATA : S_RD_ADDR;
                S_DATA:    if (frame_last) state_d = S_WR_AD;
                S_WR_AD:   if (wr_done) state_d = S_WR_RESP;
                S_WR_RESP: if (b_hs) state_d = S_TX_SEND;
                S_RD_ADDR: if (ar_hs) state_d = S_RD_DATA;
                S_RD_DATA: if (r_hs) state_d = S_TX_SEND;
                S_TX_SEND: state_d = S_TX_WAIT;
                S_TX_WAIT: if (TX_DONE) state_d = tx_last ? S_IDLE : S_TX_SEND;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        BUSY    = (state_q != S_IDLE);
        TX_DRDY = (state_q == S_TX_SEND);
        TX_DI   = 8'h00;
        if (state_q == S_TX_SEND) begin
            case (cnt_q)
                3'd0:    TX_DI = {6'b0, resp_q};
                3'd1:    TX_DI = rdata_q[AXI_DWIDTH-1  -: 8];
                3'd2:    TX_DI = rdata_q[AXI_DWIDTH-9  -: 8];
                3'd3:    TX_DI = rdata_q[AXI_DWIDTH-17 -: 8];
                default: TX_DI = rdata_q[AXI_DWIDTH-25 -: 8];
            endcase
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q && !AXI_AWREADY;
        wvalid_d  = wvalid_q && !AXI_WREADY;
        arvalid_d = arvalid_q && !AXI_ARREADY;
        bready_d  = wr_done || (bready_q && !AXI_BVALID);
        rready_d  = ar_hs || (rready_q && !AXI_RVALID);
        tmo_d     = '0;
        if (in_idle && cmd_ok) begin
            is_wr_d = (RX_DO == 8'h57);
            cnt_d   = 3'd0;
        end
        if (frame_byte) begin
            cnt_d = (cnt_q == 3'd3) ? 3'd0 : cnt_q + 3'd1;
            if (state_q == S_ADDR) addr_d  = {addr_q[AXI_AWIDTH-9:0], RX_DO};
            else                   wdata_d = {wdata_q[AXI_DWIDTH-9:0], RX_DO};
        end
        if (frame_last && (state_q == S_DATA)) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
        end
        if (frame_last && (state_q == S_ADDR) && !is_wr_q) arvalid_d = 1'b1;
        if (b_hs) begin
            resp_d = AXI_BRESP;
            cnt_d  = 3'd0;
        end
        if (r_hs) begin
            resp_d  = AXI_RRESP;
            rdata_d = AXI_RDATA;
            cnt_d   = 3'd0;
        end
        if ((state_q == S_TX_WAIT) && TX_DONE) cnt_d = cnt_q + 3'd1;
        if ((BYTE_TIMEOUT != 0) && frame_st && !tmo_hit && !RX_DRDY) tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            cnt_q     <= '0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            tmo_q     <= tmo_d;
        end
    end

    assign AXI_AWADDR  = addr_q;
    assign AXI_ARADDR  = addr_q;
    assign AXI_WDATA   = wdata_q;
    assign AXI_WSTRB   = {(AXI_DWIDTH/8){wvalid_q}};
    assign AXI_AWVALID = awvalid_q;
    assign AXI_WVALID  = wvalid_q;
    assign AXI_BREADY  = bready_q;
    assign AXI_ARVALID = arvalid_q;
    assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_uart_axi4lite_master.sv
// Directed bench for uart_axi4lite_master: AXI responder and UART TX model with
// configurable delays, scenario tasks with inline checks.
module tb_uart_axi4lite_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_do;
    logic        rx_drdy;
    logic [7:0]  tx_di;
    logic        tx_drdy;
    logic        tx_done;
    logic        busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'd0, rresp_cfg = 2'd0;
    logic [31:0] rdata_cfg = 32'h0;
    int aw_hs, w_hs, b_hs, ar_hs, r_hs, stab_err, r_hs_cyc;
    logic [31:0] aw_cap, w_cap, ar_cap;
    logic [3:0]  wstrb_cap;
    bit valid_seen;
    int tx_n, tx_order_err, tx_first_cyc;
    logic [7:0] tx_buf [16];

    uart_axi4lite_master #(.AXI_AWIDTH(32), .AXI_DWIDTH(32), .BYTE_TIMEOUT(100)) dut (
        .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
        .RX_DO(rx_do), .RX_DRDY(rx_drdy),
        .TX_DI(tx_di), .TX_DRDY(tx_drdy), .TX_DONE(tx_done), .BUSY(busy),
        .AXI_AWADDR(awaddr), .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
        .AXI_WDATA(wdata), .AXI_WSTRB(wstrb), .AXI_WVALID(wvalid), .AXI_WREADY(wready),
        .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
        .AXI_ARADDR(araddr), .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
        .AXI_RDATA(rdata), .AXI_RRESP(rresp), .AXI_RVALID(rvalid), .AXI_RREADY(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // AXI responder: inputs are changed on the falling edge, handshakes complete on the next rising edge
    initial begin
        bit aw_seen, w_seen, ar_seen, b_fire, r_fire;
        bit aw_prev, w_prev, ar_prev;
        logic [31:0] aw_prev_a, w_prev_d, ar_prev_a;
        int aw_cnt, w_cnt, ar_cnt;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_fire = 0; r_fire = 0;
        aw_prev = 0; w_prev = 0; ar_prev = 0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_prev_a = 0; w_prev_d = 0; ar_prev_a = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        forever begin
            @(negedge clk);
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (!bvalid && aw_seen && w_seen) begin
                bvalid = 1; bresp = bresp_cfg; aw_seen = 0; w_seen = 0;
            end
            if (bvalid && bready) begin b_hs++; b_fire = 1; end
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!rvalid && ar_seen) begin
                rvalid = 1; rdata = rdata_cfg; rresp = rresp_cfg; ar_seen = 0;
            end
            if (rvalid && rready) begin r_hs++; r_fire = 1; r_hs_cyc = cyc; end
            if (awvalid) begin
                if (aw_prev && awaddr !== aw_prev_a) stab_err++;
                if (aw_cnt >= aw_delay) begin
                    awready = 1; aw_hs++; aw_cap = awaddr; aw_seen = 1;
                end else begin awready = 0; aw_cnt++; end
            end else begin awready = 0; aw_cnt = 0; end
            aw_prev = awvalid; aw_prev_a = awaddr;
            if (wvalid) begin
                if (w_prev && wdata !== w_prev_d) stab_err++;
                if (w_cnt >= w_delay) begin
                    wready = 1; w_hs++; w_cap = wdata; wstrb_cap = wstrb; w_seen = 1;
                end else begin wready = 0; w_cnt++; end
            end else begin wready = 0; w_cnt = 0; end
            w_prev = wvalid; w_prev_d = wdata;
            if (arvalid) begin
                if (ar_prev && araddr !== ar_prev_a) stab_err++;
                if (ar_cnt >= ar_delay) begin
                    arready = 1; ar_hs++; ar_cap = araddr; ar_seen = 1;
                end else begin arready = 0; ar_cnt++; end
            end else begin arready = 0; ar_cnt = 0; end
            ar_prev = arvalid; ar_prev_a = araddr;
            if (awvalid || wvalid || arvalid) valid_seen = 1;
        end
    end

    // UART TX model: TX_DONE three cycles after each TX_DRDY
    initial begin
        int tx_timer;
        tx_timer = 0;
        tx_done = 0;
        forever begin
            @(negedge clk);
            tx_done = 0;
            if (tx_drdy) begin
                if (tx_timer > 0) tx_order_err++;
                if (tx_n == 0) tx_first_cyc = cyc;
                if (tx_n < 16) tx_buf[tx_n] = tx_di;
                tx_n++;
                tx_timer = 3;
            end else if (tx_timer > 0) begin
                tx_timer--;
                if (tx_timer == 0) tx_done = 1;
            end
        end
    end

    task automatic clear_mon();
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; stab_err = 0;
        aw_cap = 0; w_cap = 0; ar_cap = 0; wstrb_cap = 0; valid_seen = 0;
        tx_n = 0; tx_order_err = 0; tx_first_cyc = -1; r_hs_cyc = -100;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_do = b;
        rx_drdy = 1;
        @(negedge clk);
        rx_drdy = 0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst_n = 1; rx_do = 0; rx_drdy = 0;
        #2 rst_n = 0;
        #3;
        checks++; if ({awvalid, wvalid, arvalid, bready, rready} !== 5'b0) begin errors++;
            $display("FAIL reset_valids got %b exp 00000", {awvalid, wvalid, arvalid, bready, rready}); end
        checks++; if ({tx_drdy, busy} !== 2'b0) begin errors++;
            $display("FAIL reset_txdrdy_busy got %b exp 00", {tx_drdy, busy}); end
        checks++; if ({awaddr, wdata, araddr} !== 96'h0) begin errors++;
            $display("FAIL reset_addr_data got %h %h %h exp 0", awaddr, wdata, araddr); end
        checks++; if ({tx_di, wstrb} !== 12'h0) begin errors++;
            $display("FAIL reset_txdi_wstrb got %h %h exp 0", tx_di, wstrb); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        bit ok;
        logic [7:0] fr [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        clear_mon(); aw_delay = 0; w_delay = 0; bresp_cfg = 2'd0;
        foreach (fr[i]) send_byte(fr[i]);
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++;
            $display("FAIL wr_valid_latency got %b exp 11", {awvalid, wvalid}); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wr_timeout busy got %b exp 0", busy); end
        checks++; if (aw_cap !== 32'h4) begin errors++; $display("FAIL wr_awaddr got %h exp 00000004", aw_cap); end
        checks++; if (w_cap !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", w_cap); end
        checks++; if (wstrb_cap !== 4'hF) begin errors++; $display("FAIL wr_wstrb got %h exp f", wstrb_cap); end
        checks++; if ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, 32'd1}) begin errors++;
            $display("FAIL wr_hs_counts got aw=%0d w=%0d b=%0d exp 1 1 1", aw_hs, w_hs, b_hs); end
        checks++; if (tx_n !== 1 || tx_buf[0] !== 8'h00) begin errors++;
            $display("FAIL wr_tx got n=%0d b0=%h exp n=1 b0=00", tx_n, tx_buf[0]); end
    endtask

    task automatic test_read();
        bit ok;
        logic [7:0] fr [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h0C};
        logic [7:0] exp_tx [5] = '{8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        clear_mon(); ar_delay = 3; rdata_cfg = 32'h12345678; rresp_cfg = 2'd0;
        foreach (fr[i]) send_byte(fr[i]);
        checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL rd_arvalid_latency got %b exp 1", arvalid); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rd_timeout busy got %b exp 0", busy); end
        checks++; if (ar_cap !== 32'hC || stab_err !== 0) begin errors++;
            $display("FAIL rd_araddr got %h stab_err=%0d exp 0000000c 0", ar_cap, stab_err); end
        checks++; if ({ar_hs, r_hs, aw_hs} !== {32'd1, 32'd1, 32'd0}) begin errors++;
            $display("FAIL rd_hs_counts got ar=%0d r=%0d aw=%0d exp 1 1 0", ar_hs, r_hs, aw_hs); end
        checks++; if (tx_n !== 5 || tx_order_err !== 0) begin errors++;
            $display("FAIL rd_tx_count got n=%0d order_err=%0d exp 5 0", tx_n, tx_order_err); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (tx_buf[i] !== exp_tx[i]) begin errors++;
                $display("FAIL rd_tx_byte%0d got %h exp %h", i, tx_buf[i], exp_tx[i]); end
        end
        checks++; if (tx_first_cyc !== r_hs_cyc + 1) begin errors++;
            $display("FAIL rd_tx_latency got %0d exp %0d", tx_first_cyc, r_hs_cyc + 1); end
        ar_delay = 0;
    endtask

    task automatic test_skewed_write();
        bit ok;
        logic [7:0] fr [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        clear_mon(); aw_delay = 5; w_delay = 0; bresp_cfg = 2'd2;
        foreach (fr[i]) send_byte(fr[i]);
        @(negedge clk);
        checks++; if ({awvalid, wvalid} !== 2'b10) begin errors++;
            $display("FAIL skew_valids got %b exp 10", {awvalid, wvalid}); end
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL skew_timeout busy got %b exp 0", busy); end
        checks++; if ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, 32'd1}) begin errors++;
            $display("FAIL skew_hs_counts got aw=%0d w=%0d b=%0d exp 1 1 1", aw_hs, w_hs, b_hs); end
        checks++; if (aw_cap !== 32'h10 || w_cap !== 32'hCAFEF00D || stab_err !== 0) begin errors++;
            $display("FAIL skew_addr_data got %h %h stab_err=%0d exp 00000010 cafef00d 0", aw_cap, w_cap, stab_err); end
        checks++; if (tx_n !== 1 || tx_buf[0] !== 8'h02) begin errors++;
            $display("FAIL skew_tx got n=%0d b0=%h exp n=1 b0=02", tx_n, tx_buf[0]); end
        aw_delay = 0; bresp_cfg = 2'd0;
    endtask

    task automatic test_garbage_timeout();
        bit ok;
        logic [7:0] fr [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h20};
        clear_mon();
        send_byte(8'h41);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy got %b exp 0", busy); end
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy got %b exp 1", busy); end
        repeat (110) @(negedge clk);
        checks++; if (busy !== 1'b0 || valid_seen !== 1'b0) begin errors++;
            $display("FAIL timeout_resync got busy=%b valid_seen=%b exp 0 0", busy, valid_seen); end
        rdata_cfg = 32'hAABBCCDD;
        foreach (fr[i]) send_byte(fr[i]);
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_read_timeout busy got %b exp 0", busy); end
        checks++; if (ar_cap !== 32'h20 || ar_hs !== 1 || aw_hs !== 0) begin errors++;
            $display("FAIL tmo_read got araddr=%h ar=%0d aw=%0d exp 00000020 1 0", ar_cap, ar_hs, aw_hs); end
        checks++; if (tx_n !== 5 || tx_buf[1] !== 8'hAA || tx_buf[4] !== 8'hDD) begin errors++;
            $display("FAIL tmo_read_tx got n=%0d b1=%h b4=%h exp 5 aa dd", tx_n, tx_buf[1], tx_buf[4]); end
    endtask

    task automatic test_busy_bytes();
        bit ok;
        logic [7:0] fr [5] = '{8'h52, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_mon(); ar_delay = 4; rdata_cfg = 32'h0BADF00D;
        foreach (fr[i]) send_byte(fr[i]);
        send_byte(8'h57);
        wait_idle(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_bytes_timeout busy got %b exp 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_bytes_idle got %b exp 0", busy); end
        checks++; if ({ar_hs, r_hs, aw_hs, w_hs} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin errors++;
            $display("FAIL busy_bytes_hs got ar=%0d r=%0d aw=%0d w=%0d exp 1 1 0 0", ar_hs, r_hs, aw_hs, w_hs); end
        checks++; if (tx_n !== 5 || tx_buf[2] !== 8'hAD) begin errors++;
            $display("FAIL busy_bytes_tx got n=%0d b2=%h exp 5 ad", tx_n, tx_buf[2]); end
        ar_delay = 0;
    endtask

    task automatic test_reset_midway();
        logic [7:0] fr [9] = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_mon(); aw_delay = 20; w_delay = 20;
        foreach (fr[i]) send_byte(fr[i]);
        @(negedge clk);
        checks++; if ({awvalid, wvalid} !== 2'b11) begin errors++;
            $display("FAIL rst_mid_pre got %b exp 11", {awvalid, wvalid}); end
        #2 rst_n = 0;
        #1;
        checks++; if ({awvalid, wvalid, bready, tx_drdy, busy} !== 5'b0 || {awaddr, wdata} !== 64'h0) begin errors++;
            $display("FAIL rst_mid_outputs got %b %h %h exp 00000 0 0", {awvalid, wvalid, bready, tx_drdy, busy}, awaddr, wdata); end
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);
        checks++; if (tx_n !== 0 || busy !== 1'b0 || aw_hs !== 0) begin errors++;
            $display("FAIL rst_mid_after got tx_n=%0d busy=%b aw=%0d exp 0 0 0", tx_n, busy, aw_hs); end
        aw_delay = 0; w_delay = 0;
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_write();
        test_read();
        test_skewed_write();
        test_garbage_timeout();
        test_busy_bytes();
        test_reset_midway();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
